lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Parametrised load/store unit between the core datapath and data memory; replaces the fixed, always-idle pmem hookup.
//  Accepts one request per transaction: LB/LH/LW/LD, their unsigned forms, and SB/SH/SW/SD.
//  Aligns stores into byte lanes with a write mask, and extracts plus sign/zero-extends load data.
//  Drives a valid/ready request channel and a response channel to memory, and flags misaligned accesses and timeouts.
// PARAMETERS
//  XLEN     64  data width; 32 or 64 only.
//  ADDR_W   64  address width.
//  TIMEOUT  256 max cycles in WAIT before an error response; 0 disables the timeout.
// PORTS
//  clk             in   1         clock, all state on rising edge
//  rst_n           in   1         synchronous, active-low reset
//  req_valid       in   1         core request valid
//  req_ready       out  1         unit idle, request accepted when req_valid & req_ready
//  req_we          in   1         1 = store, 0 = load
//  req_size        in   2         0 = byte, 1 = half, 2 = word, 3 = double
//  req_unsigned    in   1         load zero-extends (LBU/LHU/LWU)
//  req_addr        in   ADDR_W    byte address
//  req_wdata       in   XLEN      store data, right-aligned
//  resp_valid      out  1         one-cycle pulse, transaction done
//  resp_err        out  1         valid with resp_valid: misaligned, size unsupported, or timeout
//  resp_rdata      out  XLEN      extended load data; 0 for stores and errors
//  mem_req_valid   out  1         memory request valid
//  mem_req_ready   in   1         memory accepts request
//  mem_we          out  1         write request
//  mem_addr        out  ADDR_W    req_addr with low log2(XLEN/8) bits cleared
//  mem_wdata       out  XLEN      store data shifted to lane offset*8
//  mem_wmask       out  XLEN/8    byte enables = ((1<<bytes)-1) << offset
//  mem_resp_valid  in   1         memory done (read data valid / write ack)
//  mem_rdata       in   XLEN      aligned read word
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT, RESP. req_ready = (state==IDLE).
//  - IDLE, on accept: latch all req_* fields.
//    Misaligned (addr % bytes != 0) or size==3 with XLEN==32 -> RESP with err=1; no memory access is issued.
//    Otherwise -> REQ.
//  - REQ: mem_req_valid=1 with mem_* held stable until mem_req_ready; on handshake -> WAIT and clear the timeout counter.
//  - WAIT: on mem_resp_valid, capture mem_rdata -> RESP, err=0.
//    Otherwise the counter increments; when it reaches TIMEOUT (TIMEOUT!=0) -> RESP with err=1 and rdata=0.
//  - RESP: resp_valid=1 for exactly one cycle -> IDLE. The core has no backpressure.
//  - mem_resp_valid is ignored outside WAIT; a late response after a timeout is dropped.
//  - mem_resp_valid in the same cycle as the REQ handshake is ignored.
//  - Load data: (rdata >> offset*8) truncated to bytes*8, then sign-extended unless req_unsigned.
//    For size 3, and size 2 on XLEN 32, no extension is applied.
//  - Latency: accept at cycle 0; REQ at cycle 1; WAIT at cycle 2; resp_valid at cycle 3 with zero-wait memory.
//    Error on decode: resp_valid at cycle 1.
//  - A new request is accepted the cycle after RESP (the unit is in IDLE again); throughput is 1 per 4 cycles minimum.
//  - Reset: rst_n low at a clock edge forces IDLE from any state and abandons any pending handshake.
//    All outputs are 0 after that edge except req_ready=1.
// TESTING
//  1. LD 0x80000008 with mem_rdata=0x8877665544332211, zero-wait memory
//     -> mem_addr=0x80000008, resp_valid at cycle 3, rdata=0x8877665544332211, err=0.
//  2. LB 0x80000003 with mem_rdata=0x00000000_F0000000 -> rdata=0xFFFFFFFFFFFFFFF0;
//     the same access as LBU -> rdata=0xF0.
//  3. SH 0x80000006 with wdata=0xABCD -> mem_wmask=0xC0, mem_wdata[63:48]=0xABCD, mem_we=1, rdata=0.
//  4. LW 0x80000002 -> resp_valid at cycle 1 with err=1; mem_req_valid never asserted.
//  5. mem_req_ready held low 5 cycles, then responding -> mem_* stable throughout; single resp_valid pulse.
//     With TIMEOUT=4 and no mem_resp_valid -> err=1 after 4 WAIT cycles; a later mem_resp_valid is ignored.
//  6. rst_n low while in REQ -> next edge: mem_req_valid=0, req_ready=1; a new request then completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the core datapath and data memory.
// One transaction at a time: decode, issue a single memory request, wait for
// the memory response (or time out), then return a one-cycle response pulse.
// Store data is placed into byte lanes with a write mask; load data is
// pulled out of the aligned word and sign- or zero-extended.
module lsu_ctrl #(
    parameter int XLEN    = 64,   // 32 or 64
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 256   // WAIT cycles before an error response, 0 = never
) (
    input  logic                clk,
    input  logic                rst_n,
    // core request
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    // core response
    output logic                resp_valid,
    output logic                resp_err,
    output logic [XLEN-1:0]     resp_rdata,
    // memory request
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    // memory response
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state, next_state;

    // transaction fields captured at accept
    logic               lat_we;
    logic [1:0]         lat_size;
    logic               lat_unsigned;
    logic [ADDR_W-1:0]  lat_addr;
    logic [XLEN-1:0]    lat_wdata;

    // response payload built up during the transaction
    logic               err;
    logic [XLEN-1:0]    rdata;
    logic [CNT_W-1:0]   wait_cnt;

    logic               misaligned;
    logic               size_bad;
    logic               dec_err;
    logic               timeout_hit;
    logic [OFF_W-1:0]   offset;
    logic [NB-1:0]      lane_mask;

    // Shift the addressed lane down, keep the access width, then extend.
    // Accesses as wide as XLEN (LD, or LW on a 32-bit unit) pass through.
    function automatic logic [XLEN-1:0] load_ext(
        input logic [XLEN-1:0]  raw,
        input logic [OFF_W-1:0] off,
        input logic [1:0]       size,
        input logic             uns
    );
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] ext;
        logic            sgn;
        int              nbits;
        sh    = raw >> {off, 3'b000};
        nbits = 8 << size;
        if (nbits > XLEN) nbits = XLEN;
        sgn = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == nbits - 1) sgn = sh[i];
        end
        if (uns) sgn = 1'b0;
        ext = '0;
        for (int i = 0; i < XLEN; i++) begin
            ext[i] = (i < nbits) ? sh[i] : sgn;
        end
        return ext;
    endfunction

    // Decode-time checks on the incoming request: natural alignment and size support.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
        size_bad = (req_size == 2'd3) && (XLEN == 32);
        dec_err  = misaligned || size_bad;
    end

    assign timeout_hit = (TIMEOUT != 0) && (state == S_WAIT) && !mem_resp_valid
                         && (wait_cnt == TO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state    = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = dec_err ? S_RESP : S_REQ;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) next_state = S_WAIT;
            end
            S_WAIT: begin
                // a response always wins over a timeout landing the same cycle
                if (mem_resp_valid || timeout_hit) next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Transaction fields, wait counter and response payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_we       <= 1'b0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            err          <= 1'b0;
            rdata        <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        err          <= dec_err;
                        rdata        <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        err   <= 1'b0;
                        rdata <= lat_we ? '0
                                        : load_ext(mem_rdata, offset, lat_size, lat_unsigned);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout_hit) begin
                            err   <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign offset = lat_addr[OFF_W-1:0];

    // Byte enables cover [offset, offset+bytes) of the aligned word.
    always_comb begin
        int off_i;
        int bytes_i;
        lane_mask = '0;
        off_i     = int'(offset);
        bytes_i   = 1 << lat_size;
        for (int b = 0; b < NB; b++) begin
            lane_mask[b] = (b >= off_i) && (b < off_i + bytes_i);
        end
    end

    // Memory-side fields are only driven while the request is presented,
    // so they read as zero whenever the unit is not talking to memory.
    assign mem_we     = mem_req_valid & lat_we;
    assign mem_addr   = mem_req_valid ? (lat_addr & ~ADDR_W'(NB - 1)) : '0;
    assign mem_wdata  = mem_req_valid ? (lat_wdata << {offset, 3'b000}) : '0;
    assign mem_wmask  = mem_req_valid ? lane_mask : '0;

    assign resp_err   = resp_valid & err;
    assign resp_rdata = resp_valid ? rdata : '0;

endmodule
